control: RTL and testbench

//  Main control unit of the single-issue MIPS-style datapath. Decodes the 6-bit

---
 rtl/control_pkg.sv | 36 +++
 rtl/control_decode.sv | 48 ++++
 rtl/control.sv | 49 ++++
 tb/tb_control.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared opcode and ALU operation-class constants plus the control bundle type.
// Used by the main control unit and by the downstream ALU-control block.
package control_pkg;

    localparam int unsigned OP_W     = 6;
    localparam int unsigned ALU_OP_W = 3;

    // Primary opcodes, instr[31:26]
    localparam logic [OP_W-1:0] OP_RTYPE = 6'd0;
    localparam logic [OP_W-1:0] OP_LW    = 6'd39;
    localparam logic [OP_W-1:0] OP_SW    = 6'd40;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'd41;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'd42;

    // ALU operation classes; 3'b110 and 3'b111 are reserved
    localparam logic [ALU_OP_W-1:0] ALU_ADD   = 3'b000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB   = 3'b001;
    localparam logic [ALU_OP_W-1:0] ALU_RTYPE = 3'b010;
    localparam logic [ALU_OP_W-1:0] ALU_AND   = 3'b011;
    localparam logic [ALU_OP_W-1:0] ALU_OR    = 3'b100;
    localparam logic [ALU_OP_W-1:0] ALU_SLT   = 3'b101;

    // Datapath steering bundle
    typedef struct packed {
        logic                reg_dst;
        logic                alu_src;
        logic                mem_to_reg;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic [ALU_OP_W-1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/control_decode.sv
// Pure combinational opcode decoder.
// Ports:
//   op      in  opcode field instr[31:26]
//   ctrl_c  out decoded control bundle (combinational)
// Unknown opcodes, including any X/Z pattern, decode to an all-zero bundle.
module control_decode
    import control_pkg::*;
(
    input  logic [OP_W-1:0] op,
    output ctrl_t           ctrl_c
);

    // Opcode -> control bundle; everything not set explicitly stays 0
    always_comb begin
        ctrl_c = CTRL_NOP;
        case (op)
            OP_RTYPE: begin
                ctrl_c.reg_dst   = 1'b1;
                ctrl_c.reg_write = 1'b1;
                ctrl_c.alu_op    = ALU_RTYPE;
            end
            OP_LW: begin
                ctrl_c.alu_src    = 1'b1;
                ctrl_c.mem_to_reg = 1'b1;
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.mem_read   = 1'b1;
                ctrl_c.alu_op     = ALU_ADD;
            end
            OP_SW: begin
                ctrl_c.alu_src   = 1'b1;
                ctrl_c.mem_write = 1'b1;
                ctrl_c.alu_op    = ALU_ADD;
            end
            OP_ADDI: begin
                ctrl_c.alu_src   = 1'b1;
                ctrl_c.reg_write = 1'b1;
                ctrl_c.alu_op    = ALU_ADD;
            end
            OP_SLTI: begin
                ctrl_c.alu_src   = 1'b1;
                ctrl_c.reg_write = 1'b1;
                ctrl_c.alu_op    = ALU_SLT;
            end
            default: ctrl_c = CTRL_NOP;
        endcase
    end

endmodule

// File: rtl/control.sv
// Main control unit: decodes the opcode and registers the steering signals.
// Ports:
//   clk       in  clock, rising edge
//   rst       in  asynchronous active-high reset, clears all outputs
//   Op        in  opcode field instr[31:26]
//   RegDst, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite  out  1-bit controls
//   ALUOp     out 3-bit ALU operation class
// Outputs reflect the Op sampled at the previous rising edge.
module control
    import control_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [OP_W-1:0]     Op,
    output logic                RegDst,
    output logic                MemRead,
    output logic                MemtoReg,
    output logic [ALU_OP_W-1:0] ALUOp,
    output logic                MemWrite,
    output logic                ALUSrc,
    output logic                RegWrite
);

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    control_decode u_decode (
        .op     (Op),
        .ctrl_c (ctrl_d)
    );

    // Output register bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= CTRL_NOP;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign RegDst   = ctrl_q.reg_dst;
    assign ALUSrc   = ctrl_q.alu_src;
    assign MemtoReg = ctrl_q.mem_to_reg;
    assign RegWrite = ctrl_q.reg_write;
    assign MemRead  = ctrl_q.mem_read;
    assign MemWrite = ctrl_q.mem_write;
    assign ALUOp    = ctrl_q.alu_op;

endmodule

// File: tb/tb_control.sv
// Bench for the main control unit: directed decodes, full opcode sweep,
// random opcode stream and async reset behaviour, against a lookup-table model.
module tb_control;

    logic       clk;
    logic       rst;
    logic [5:0] Op;
    logic       RegDst;
    logic       MemRead;
    logic       MemtoReg;
    logic [2:0] ALUOp;
    logic       MemWrite;
    logic       ALUSrc;
    logic       RegWrite;

    int total;
    int bad;

    // Expected vector layout: {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,ALUOp}
    logic [8:0] ref_tbl [64];
    logic [8:0] exp_q;

    control dut (
        .clk      (clk),
        .rst      (rst),
        .Op       (Op),
        .RegDst   (RegDst),
        .MemRead  (MemRead),
        .MemtoReg (MemtoReg),
        .ALUOp    (ALUOp),
        .MemWrite (MemWrite),
        .ALUSrc   (ALUSrc),
        .RegWrite (RegWrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] outs();
        return {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // One cycle: drive at negedge, confirm outputs held, then check after the edge
    task automatic step(input logic [5:0] op, input logic r, input string tag);
        @(negedge clk);
        rst = r;
        Op  = op;
        #1;
        if (r) exp_q = '0;
        chk($sformatf("%s_hold op=%0d", tag, op), 32'(outs()), 32'(exp_q));
        @(posedge clk);
        #1;
        exp_q = r ? 9'd0 : ref_tbl[op];
        chk($sformatf("%s op=%0d", tag, op), 32'(outs()), 32'(exp_q));
        chk($sformatf("%s_rdwr op=%0d", tag, op), 32'(MemRead & MemWrite), 32'd0);
        chk($sformatf("%s_wrreg op=%0d", tag, op), 32'(MemWrite & RegWrite), 32'd0);
    endtask

    initial begin
        int unsigned nz;
        total = 0;
        bad   = 0;
        for (int i = 0; i < 64; i++) ref_tbl[i] = 9'd0;
        ref_tbl[0]  = 9'b1_0_0_1_0_0_010;
        ref_tbl[39] = 9'b0_1_1_1_1_0_000;
        ref_tbl[40] = 9'b0_1_0_0_0_1_000;
        ref_tbl[41] = 9'b0_1_0_1_0_0_000;
        ref_tbl[42] = 9'b0_1_0_1_0_0_101;

        // Reset asserts before any clock edge
        rst = 1'b0;
        Op  = 6'd39;
        #1 rst = 1'b1;
        #1;
        exp_q = '0;
        chk("reset_noclk", 32'(outs()), 32'd0);

        // Held in reset across edges with decodable opcodes
        step(6'd0,  1'b1, "in_reset");
        step(6'd39, 1'b1, "in_reset");

        // Release: first edge loads the opcode present at that edge
        step(6'd0,  1'b0, "rtype");
        chk("rtype_regdst", 32'(RegDst), 32'd1);
        chk("rtype_aluop", 32'(ALUOp), 32'd2);
        step(6'd39, 1'b0, "lw");
        chk("lw_memread", 32'(MemRead), 32'd1);
        chk("lw_memtoreg", 32'(MemtoReg), 32'd1);
        step(6'd40, 1'b0, "sw");
        chk("sw_memwrite", 32'(MemWrite), 32'd1);
        chk("sw_regwrite", 32'(RegWrite), 32'd0);
        step(6'd41, 1'b0, "addi");
        chk("addi_alusrc", 32'(ALUSrc), 32'd1);
        step(6'd42, 1'b0, "slti");
        chk("slti_aluop", 32'(ALUOp), 32'd5);
        step(6'd54, 1'b0, "undef");

        // Full sweep; count opcodes giving a non-zero decode
        nz = 0;
        for (int i = 0; i < 64; i++) begin
            step(6'(i), 1'b0, "sweep");
            if (outs() != 9'd0) nz++;
        end
        chk("sweep_nonzero_cnt", 32'(nz), 32'd5);

        // Random stream biased towards the defined opcodes
        for (int n = 0; n < 200; n++) begin
            logic [5:0] op;
            case ($urandom_range(0, 3))
                0:       op = 6'd0;
                1:       op = 6'(39 + $urandom_range(0, 3));
                default: op = 6'($urandom_range(0, 63));
            endcase
            step(op, 1'b0, "rand");
        end

        // Mid-cycle async reset while an LW decode is held
        step(6'd39, 1'b0, "pre_rst");
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        exp_q = '0;
        chk("midrst_async", 32'(outs()), 32'd0);
        step(6'd39, 1'b1, "midrst_held");
        step(6'd39, 1'b0, "midrst_release");
        chk("midrst_lw", 32'(outs()), 32'(9'b0_1_1_1_1_0_000));

        // Random reset pulses interleaved with traffic
        for (int n = 0; n < 60; n++) begin
            step(6'($urandom_range(0, 63)), 1'($urandom_range(0, 4) == 0), "rand_rst");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
